// File: rtl/map_rom_scheduler_pkg.sv
// Shared constants, state encoding and next-line row helper for the map ROM scheduler.
package map_rom_scheduler_pkg;
    localparam int H_VIEW     = 640;
    localparam int V_TOTAL    = 525;
    localparam int MAP_WBITS  = 4;
    localparam int MAP_HBITS  = 4;
    localparam int MAP_SCALE  = 3;
    localparam int MAP_WIDTH  = 1 << MAP_WBITS;
    localparam int MAP_HEIGHT = 1 << MAP_HBITS;

    typedef enum logic {
        MRS_IDLE  = 1'b0,
        MRS_FETCH = 1'b1
    } mrs_state_e;

    // Map row that the overlay will draw on the line after vpos (wraps at frame end).
    function automatic logic [MAP_HBITS-1:0] next_frow(input logic [9:0] vpos);
        logic [9:0] vnext;
        vnext = (vpos == 10'(V_TOTAL - 1)) ? 10'd0 : vpos + 10'd1;
        return vnext[MAP_SCALE+MAP_HBITS-1:MAP_SCALE];
    endfunction
endpackage

// File: rtl/map_rom_scheduler_if.sv
// Raster, tracer, overlay and map ROM signals seen by the scheduler.
interface map_rom_scheduler_if;
    import map_rom_scheduler_pkg::*;

    logic [9:0]           hpos;
    logic [9:0]           vpos;
    logic                 i_trc_req;
    logic [MAP_WBITS-1:0] i_trc_col;
    logic [MAP_HBITS-1:0] i_trc_row;
    logic                 o_trc_gnt;
    logic [1:0]           o_trc_val;
    logic [MAP_WBITS-1:0] i_ovl_col;
    logic [1:0]           o_ovl_val;
    logic [MAP_WBITS-1:0] o_map_col;
    logic [MAP_HBITS-1:0] o_map_row;
    logic [1:0]           i_map_val;
    logic                 o_busy;

    modport master (
        output hpos, vpos, i_trc_req, i_trc_col, i_trc_row, i_ovl_col, i_map_val,
        input  o_trc_gnt, o_trc_val, o_ovl_val, o_map_col, o_map_row, o_busy
    );

    modport slave (
        input  hpos, vpos, i_trc_req, i_trc_col, i_trc_row, i_ovl_col, i_map_val,
        output o_trc_gnt, o_trc_val, o_ovl_val, o_map_col, o_map_row, o_busy
    );
endinterface

// File: rtl/map_row_buffer.sv
// One map row of 2-bit cells: synchronous write port, asynchronous read port.
module map_row_buffer #(
    parameter int WBITS = 4
) (
    input  logic             clk,
    input  logic             we,
    input  logic [WBITS-1:0] waddr,
    input  logic [1:0]       wdata,
    input  logic [WBITS-1:0] raddr,
    output logic [1:0]       rdata
);
    localparam int DEPTH = 1 << WBITS;

    logic [DEPTH-1:0][1:0] mem;

    // Per-cell write decode; contents are don't-care until the first full fetch.
    for (genvar i = 0; i < DEPTH; i++) begin : g_cell
        always_ff @(posedge clk) begin
            if (we && waddr == WBITS'(i))
                mem[i] <= wdata;
        end
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/map_rom_scheduler.sv
// Arbitrates the map ROM between tracer and an hblank row prefetch feeding the overlay buffer.
module map_rom_scheduler
    import map_rom_scheduler_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    map_rom_scheduler_if.slave bus
);
    mrs_state_e           state;
    logic [MAP_WBITS-1:0] cnt;
    logic [MAP_HBITS-1:0] fetch_row;
    logic [MAP_HBITS-1:0] tag;
    logic                 valid;
    logic [MAP_HBITS-1:0] frow;
    logic                 fetching;
    logic [1:0]           buf_rdata;

    assign frow     = next_frow(bus.vpos);
    assign fetching = (state == MRS_FETCH);

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= MRS_IDLE;
            cnt       <= '0;
            valid     <= 1'b0;
            tag       <= '0;
            fetch_row <= '0;
        end else begin
            case (state)
                MRS_IDLE: begin
                    // Skip the fetch when the buffer already holds the row the next line needs.
                    if (bus.hpos == 10'(H_VIEW) && !(valid && tag == frow)) begin
                        state     <= MRS_FETCH;
                        fetch_row <= frow;
                        cnt       <= '0;
                    end
                end
                MRS_FETCH: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == MAP_WBITS'(MAP_WIDTH - 1)) begin
                        state <= MRS_IDLE;
                        valid <= 1'b1;
                        tag   <= fetch_row;
                    end
                end
                default: state <= MRS_IDLE;
            endcase
        end
    end

    map_row_buffer #(.WBITS(MAP_WBITS)) u_row_buf (
        .clk   (clk),
        .we    (fetching && !reset),
        .waddr (cnt),
        .wdata (bus.i_map_val),
        .raddr (bus.i_ovl_col),
        .rdata (buf_rdata)
    );

    assign bus.o_map_col = fetching ? cnt       : bus.i_trc_col;
    assign bus.o_map_row = fetching ? fetch_row : bus.i_trc_row;
    assign bus.o_trc_gnt = bus.i_trc_req && !fetching;
    assign bus.o_trc_val = bus.i_map_val;
    assign bus.o_ovl_val = valid ? buf_rdata : 2'b00;
    assign bus.o_busy    = fetching;
endmodule

// File: tb/tb_map_rom_scheduler.sv
// Directed bench for map_rom_scheduler with a per-cycle behavioural model and literal spot checks.
module tb_map_rom_scheduler;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   errors = 0;
    int   checks = 0;
    bit   chk_en = 1'b0;

    map_rom_scheduler_if bus();

    map_rom_scheduler dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Map ROM: value = (col + row) mod 4, combinational.
    assign bus.i_map_val = 2'(bus.o_map_col + bus.o_map_row);

    // Behavioural model: a fetch is "16 cells still to copy from row m_row".
    int m_left = 0;
    int m_idx  = 0;
    int m_row  = 0;
    bit m_valid = 1'b0;
    int m_tag  = 0;
    int m_buf [16];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        int vn, fr;
        if (reset) begin
            m_left  = 0;
            m_valid = 1'b0;
            m_tag   = 0;
        end else if (m_left > 0) begin
            m_buf[m_idx] = (m_idx + m_row) % 4;
            m_idx++;
            m_left--;
            if (m_left == 0) begin
                m_valid = 1'b1;
                m_tag   = m_row;
            end
        end else if (int'(bus.hpos) == 640) begin
            vn = (int'(bus.vpos) == 524) ? 0 : int'(bus.vpos) + 1;
            fr = (vn / 8) % 16;
            if (!(m_valid && m_tag == fr)) begin
                m_left = 16;
                m_idx  = 0;
                m_row  = fr;
            end
        end
    end

    always @(negedge clk) begin
        bit busy_e, gnt_e;
        if (chk_en) begin
            busy_e = (m_left > 0);
            gnt_e  = bus.i_trc_req && !busy_e;
            chk("m_busy", int'(bus.o_busy), int'(busy_e));
            chk("m_gnt", int'(bus.o_trc_gnt), int'(gnt_e));
            chk("m_col", int'(bus.o_map_col), busy_e ? m_idx : int'(bus.i_trc_col));
            chk("m_row", int'(bus.o_map_row), busy_e ? m_row : int'(bus.i_trc_row));
            if (gnt_e)
                chk("m_trc_val", int'(bus.o_trc_val), (int'(bus.i_trc_col) + int'(bus.i_trc_row)) % 4);
            chk("m_ovl", int'(bus.o_ovl_val), m_valid ? m_buf[int'(bus.i_ovl_col)] : 0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulse hpos=640 for one cycle at vp and count the busy cycles that follow.
    task automatic hblank(input int vp, input bit col_chk, output int n);
        bus.vpos = 10'(vp);
        bus.hpos = 10'd640;
        tick();
        bus.hpos = 10'd641;
        n = 0;
        while (bus.o_busy === 1'b1 && n < 100) begin
            if (col_chk) begin
                chk("t2_col", int'(bus.o_map_col), n);
                chk("t2_row", int'(bus.o_map_row), 1);
                chk("t2_gnt", int'(bus.o_trc_gnt), 0);
            end
            n++;
            tick();
        end
    endtask

    initial begin
        int n;
        bus.hpos = '0;
        bus.vpos = '0;
        bus.i_trc_req = 1'b1;
        bus.i_trc_col = '0;
        bus.i_trc_row = '0;
        bus.i_ovl_col = '0;

        // 1: reset
        tick();
        tick();
        chk_en = 1'b1;
        chk("t1_gnt", int'(bus.o_trc_gnt), 1);
        chk("t1_busy", int'(bus.o_busy), 0);
        chk("t1_ovl", int'(bus.o_ovl_val), 0);
        reset = 1'b0;
        tick();

        // 2: fetch row 1 from vpos 7
        hblank(7, 1'b1, n);
        chk("t2_cycles", n, 16);
        bus.i_ovl_col = 4'd5;
        #1;
        chk("t2_ovl5", int'(bus.o_ovl_val), 2);
        for (int c = 0; c < 16; c++) begin
            bus.i_ovl_col = 4'(c);
            tick();
        end

        // 3: same row reused, then row 2
        for (int v = 8; v <= 14; v++) begin
            hblank(v, 1'b0, n);
            chk("t3_nofetch", n, 0);
        end
        hblank(15, 1'b0, n);
        chk("t3_row2_cycles", n, 16);
        bus.i_ovl_col = 4'd5;
        #1;
        chk("t3_ovl5", int'(bus.o_ovl_val), 3);

        // 4: last line wraps to row 0
        hblank(524, 1'b0, n);
        chk("t4_cycles", n, 16);
        bus.i_ovl_col = 4'd3;
        #1;
        chk("t4_ovl3", int'(bus.o_ovl_val), 3);

        // 5: reset at cnt=6, then refetch of the same row
        bus.vpos = 10'd7;
        bus.hpos = 10'd640;
        tick();
        bus.hpos = 10'd641;
        for (int i = 0; i < 6; i++) tick();
        chk("t5_cnt6", int'(bus.o_map_col), 6);
        reset = 1'b1;
        tick();
        chk("t5_busy", int'(bus.o_busy), 0);
        chk("t5_ovl", int'(bus.o_ovl_val), 0);
        chk("t5_gnt", int'(bus.o_trc_gnt), 1);
        reset = 1'b0;
        tick();
        hblank(7, 1'b0, n);
        chk("t5_refetch", n, 16);
        bus.i_ovl_col = 4'd5;
        #1;
        chk("t5_ovl5", int'(bus.o_ovl_val), 2);

        // 6: tracer lookup in idle
        bus.i_trc_req = 1'b1;
        bus.i_trc_col = 4'd9;
        bus.i_trc_row = 4'd4;
        #1;
        chk("t6_col", int'(bus.o_map_col), 9);
        chk("t6_row", int'(bus.o_map_row), 4);
        chk("t6_val", int'(bus.o_trc_val), 1);
        chk("t6_gnt", int'(bus.o_trc_gnt), 1);
        bus.i_trc_req = 1'b0;
        #1;
        chk("t6_nogreq", int'(bus.o_trc_gnt), 0);
        tick();
        tick();

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
